// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I data memory with load/store unit (byte/half/word, sign/zero extend, error flagging)
// Optional DMEM_LSU_MISALIGN_SPLIT_EN: misaligned half/word accesses are split across two words.
module dmem_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int DEPTH = 2 ** ADDR_W;

`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, RSP, SPLIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RSP} state_t;
`endif

  state_t state, state_next;
  logic [31:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        k;
  logic [1:0]        sz;
  logic              f3_ok, range_err, misal, split, err;
  logic [3:0]        be_base;
  logic [31:0]       load_sh;

  assign accept    = req_valid && (state == IDLE);
  assign word_idx  = req_addr[ADDR_W+1:2];
  assign k         = req_addr[1:0];
  assign sz        = req_funct3[1:0];
  assign range_err = |req_addr[31:ADDR_W+2];
  assign misal     = (sz == 2'b01 && k[0]) || (sz == 2'b10 && k != 2'b00);
  assign f3_ok     = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                            : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign load_sh   = mem[word_idx] >> {k, 3'b000};

  always_comb begin
    be_base = 4'b1111;
    case (sz)
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
  end

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'b0, v[7:0]};
      3'b101:  return {16'b0, v[15:0]};
      default: return v;
    endcase
  endfunction

`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
  // Lanes shifted across a 64-bit window; the upper half targets word A+1.
  logic [7:0]        be_w;
  logic [63:0]       data_w;
  logic [ADDR_W-1:0] hold_idx;
  logic [1:0]        hold_k;
  logic [2:0]        hold_f3;
  logic              hold_we;
  logic [3:0]        hold_be;
  logic [31:0]       hold_data, lo_word, split_sh;

  assign be_w     = {4'b0000, be_base} << k;
  assign data_w   = {32'b0, req_wdata} << {k, 3'b000};
  assign split    = f3_ok && !range_err && misal && !(&word_idx);
  assign err      = !f3_ok || range_err || (misal && !split);
  assign split_sh = 32'({mem[hold_idx], lo_word} >> {hold_k, 3'b000});
`else
  logic [3:0]  be_w;
  logic [31:0] data_w;

  assign be_w   = be_base << k;
  assign data_w = req_wdata << {k, 3'b000};
  assign split  = 1'b0;
  assign err    = !f3_ok || range_err || misal;
`endif

  // Memory and split bookkeeping are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++)
        if (be_w[i]) mem[word_idx][8*i +: 8] <= data_w[8*i +: 8];
    end
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
    if (accept) begin
      hold_idx  <= word_idx + 1'b1;
      hold_k    <= k;
      hold_f3   <= req_funct3;
      hold_we   <= req_we;
      hold_be   <= be_w[7:4];
      hold_data <= data_w[63:32];
      lo_word   <= mem[word_idx];
    end
    if (state == SPLIT && hold_we) begin
      for (int i = 0; i < 4; i++)
        if (hold_be[i]) mem[hold_idx][8*i +: 8] <= hold_data[8*i +: 8];
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        rsp_err   <= err;
        rsp_rdata <= (err || req_we || split) ? '0 : extend(load_sh, req_funct3);
      end
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
      else if (state == SPLIT) begin
        rsp_rdata <= hold_we ? '0 : extend(split_sh, hold_f3);
      end
`endif
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
        if (accept) state_next = split ? SPLIT : RSP;
`else
        if (accept) state_next = RSP;
`endif
      end
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
      SPLIT: state_next = RSP;
`endif
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
// Expectations follow DMEM_LSU_MISALIGN_SPLIT_EN when defined.
module tb_dmem_lsu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int passed = 0;
  int total  = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  dmem_lsu #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One request with rsp_ready high; returns data, error and latency in cycles.
  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err_o, output int lat_o);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("ready_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    lat_o = 1;
    while (rsp_valid !== 1'b1 && lat_o < 10) begin @(negedge clk); lat_o++; end
    rdata = rsp_rdata;
    err_o = rsp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    xfer(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("sw_err", {31'b0, er}, 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_lat", lat, 32'd1);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {31'b0, er}, 32'd0);
    check("lw_lat", lat, 32'd1);

    xfer(1'b1, 3'b000, 32'h11, 32'h12345680, rd, er, lat);
    check("sb_err", {31'b0, er}, 32'd0);
    xfer(1'b0, 3'b000, 32'h11, 32'h0, rd, er, lat);
    check("lb_rdata", rd, 32'hFFFFFF80);
    xfer(1'b0, 3'b100, 32'h11, 32'h0, rd, er, lat);
    check("lbu_rdata", rd, 32'h00000080);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("word_after_sb", rd, 32'hDEAD80EF);

    xfer(1'b1, 3'b001, 32'h12, 32'hFFFFA5C3, rd, er, lat);
    xfer(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat);
    check("lh_rdata", rd, 32'hFFFFA5C3);
    xfer(1'b0, 3'b101, 32'h12, 32'h0, rd, er, lat);
    check("lhu_rdata", rd, 32'h0000A5C3);
    xfer(1'b1, 3'b010, 32'h14, 32'h11223344, rd, er, lat);
    xfer(1'b1, 3'b010, 32'h18, 32'h55667788, rd, er, lat);

    xfer(1'b0, 3'b001, 32'h13, 32'h0, rd, er, lat);
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
    check("lh_mis_rdata", rd, 32'h000044A5);
    check("lh_mis_err", {31'b0, er}, 32'd0);
    check("lh_mis_lat", lat, 32'd2);
`else
    check("lh_mis_rdata", rd, 32'd0);
    check("lh_mis_err", {31'b0, er}, 32'd1);
    check("lh_mis_lat", lat, 32'd1);
    xfer(1'b1, 3'b010, 32'h12, 32'h0, rd, er, lat);
    check("sw_mis_err", {31'b0, er}, 32'd1);
`endif
    xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("word_after_mis", rd, 32'hA5C380EF);

    xfer(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
    check("oor_lw_err", {31'b0, er}, 32'd1);
    check("oor_lw_rdata", rd, 32'd0);
    xfer(1'b1, 3'b010, 32'h1010, 32'h0, rd, er, lat);
    check("oor_sw_err", {31'b0, er}, 32'd1);
    xfer(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    check("f3_011_ld_err", {31'b0, er}, 32'd1);
    check("f3_011_ld_rdata", rd, 32'd0);
    xfer(1'b1, 3'b011, 32'h10, 32'h0, rd, er, lat);
    check("f3_011_st_err", {31'b0, er}, 32'd1);
    xfer(1'b1, 3'b100, 32'h10, 32'h0, rd, er, lat);
    check("f3_100_st_err", {31'b0, er}, 32'd1);
    xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("word_no_write", rd, 32'hA5C380EF);

    // Back-pressure: response held three cycles while a second request waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
    @(posedge clk);
    #1 req_funct3 = 3'b100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'h11223344);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_consumed_valid", {31'b0, rsp_valid}, 32'd0);
    check("bp_consumed_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", {31'b0, rsp_valid}, 32'd1);
    check("bp_next_rdata", rsp_rdata, 32'h00000044);
    @(posedge clk);
    #1;

`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
    // Reset while the split store sits in SPLIT: first word kept, second dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h16;
    req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    #1 check("split_rst_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    xfer(1'b0, 3'b010, 32'h14, 32'h0, rd, er, lat);
    check("split_rst_word_a", rd, 32'hBABE3344);
    xfer(1'b0, 3'b010, 32'h18, 32'h0, rd, er, lat);
    check("split_rst_word_a1", rd, 32'h55667788);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised data memory with an integrated load/store unit for the RV32I core. Accepts one load or store per request through a valid/ready handshake and supports byte, halfword and word sizes, with sign or zero extension on loads. Reads are synchronous with registered responses. Misaligned, out-of-range and illegal-size accesses are flagged with an error response. It replaces the flat word-only data memory on the ALU-result/rs2 path, between the ALU and the write-back mux.

## Interface
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W 32-bit words
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2), right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  access rejected, no memory side effect

## Operation
- States: IDLE, SPLIT (macro-only), RSP. req_ready = (state==IDLE).
- Handshake: a request is accepted on an edge where req_valid && req_ready are both high. A response is consumed on an edge where rsp_valid && rsp_ready are both high. rsp_* hold stable until consumed.
- Word index A = req_addr[ADDR_W+1:2]; byte offset k = req_addr[1:0].
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is an error.
- Range error: any bit of req_addr[31:ADDR_W+2] is set.
- Alignment: a halfword is misaligned when k[0]=1; a word is misaligned when k!=0.
- Aligned store: byte-enables are derived from size and k; the data is lane-shifted (wdata[7:0] to lane k for SB, wdata[15:0] to lanes k/k+1 for SH). The write occurs on the accept edge. Unselected bytes are unchanged.
- Aligned load: mem[A] is registered on the accept edge. The selected bytes are shifted down and sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Error response: no write, rsp_rdata=0, rsp_err=1.
- After any accepted request, state goes to RSP. From RSP, consuming the response returns the state to IDLE.
- Memory contents are not reset. Reset forces state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready is high immediately after reset deasserts.
- Reset during SPLIT: the first-word write of a split store persists and the second write is dropped. No response is issued.

## Timing
- Accept at edge T. For aligned or error requests, rsp_valid rises in cycle T+1.
- A split access (macro on) has rsp_valid in cycle T+2.
- Minimum spacing between accepts is 2 cycles: one cycle in RSP with rsp_ready=1.
- Back-pressure: each cycle rsp_ready=0 extends RSP by one cycle. req_ready stays 0 throughout.
- Store-then-load to the same address returns the new data, because the write completes before the next accept is possible.
- The first-cycle output is combinational from state only. There are no combinational paths from req_* to rsp_*.

## Configuration
- DMEM_LSU_MISALIGN_SPLIT_EN defined:
  - Misaligned LH/LHU/LW/SH/SW with A+1 < depth is split into two word accesses.
  - Edge T accesses word A and the state goes to SPLIT. Edge T+1 accesses word A+1.
  - Loads concatenate {mem[A+1],mem[A]} >> 8k, then extend.
  - Stores write the low lanes k..3 of word A, then the remaining lanes of word A+1.
  - If A+1 == depth, the access is an error at accept and neither word is touched.
- Undefined: all misaligned accesses are errors, the SPLIT state is not synthesised, and latency is always 1.

## Test plan
- Reset, then SW 0xDEADBEEF at 0x10, then LW at 0x10. Required: LW returns rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid one cycle after the LW accept.
- SB 0x80 at 0x11, then LB at 0x11 and LBU at 0x11. Required: LB returns 0xFFFFFF80, LBU returns 0x00000080, and word 0x10 reads 0xDEAD80EF.
- LH at 0x13 with the macro off. Required: rsp_err=1, rsp_rdata=0, memory unchanged. The same LH with the macro on returns bytes [0x14,0x13] sign-extended, at latency 2.
- Out-of-range LW at 4*depth, and funct3=011. Required: both give rsp_err=1 with no write.
- Back-pressure: hold rsp_ready=0 for 3 cycles. Required: rsp_* stable, req_ready=0, and a new req_valid is not accepted until the cycle after the response is consumed.
- Assert reset in SPLIT during a misaligned SW. Required: rsp_valid=0 immediately, word A updated, word A+1 unchanged.
